// File: rtl/irrigacao_multizona.sv
// Multi-zone irrigation controller: tank fill supervision, round-robin zone watering,
// alarm outputs and a 4-digit multiplexed display. Optional rain input under RAIN_SENSOR_EN.
module irrigacao_multizona #(
  parameter int ZONES      = 4,
  parameter int TICK_DIV   = 50000,
  parameter int SCAN_DIV   = 1000,
  parameter int WATER_TIME = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_low,
  input  logic             s_mid,
  input  logic             s_high,
  input  logic [ZONES-1:0] zone_req,
`ifdef RAIN_SENSOR_EN
  input  logic             chuva,
`endif
  output logic [ZONES-1:0] zone_valve,
  output logic             pump,
  output logic             led_vermelho,
  output logic             led_verde,
  output logic             led_azul,
  output logic             buzzer,
  output logic [3:0]       dig,
  output logic [6:0]       seg,
  output logic             ponto
);

  localparam int ZW   = (ZONES > 1) ? $clog2(ZONES) : 1;
  localparam int SUMW = ZW + 1;
  localparam int TW   = $clog2(TICK_DIV);
  localparam int SW   = $clog2(SCAN_DIV);
  localparam logic [SUMW-1:0] ZONES_W   = SUMW'(ZONES);
  localparam logic [ZW-1:0]   ZONE_LAST = ZW'(ZONES - 1);
  localparam logic [3:0]      WT_TENS   = 4'(WATER_TIME / 10);
  localparam logic [3:0]      WT_UNITS  = 4'(WATER_TIME % 10);

  // Display symbol codes: 0-9 are digits, the rest are glyphs.
  localparam logic [3:0] SYM_F     = 4'hA;
  localparam logic [3:0] SYM_DASH  = 4'hB;
  localparam logic [3:0] SYM_BLANK = 4'hC;

  typedef enum logic [2:0] {IDLE, FILL, SELECT, WATER, FAULT} state_t;

  state_t          state, state_nx;
  logic            rain;
  logic [1:0]      level;
  logic            code_valid;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [ZW-1:0]   rr, sel, pick, nxt_zone;
  logic            found;
  logic [3:0]      t_tens, t_units;
  logic            timer_zero;
  logic            fault_ok;
  logic            buzz_q;
  logic [SW-1:0]   scan_cnt;
  logic            scan_step;
  logic [1:0]      dig_idx, dig_idx_nx;
  logic [3:0]      sym;
  logic            dot_nx;

`ifdef RAIN_SENSOR_EN
  assign rain = chuva;
`else
  assign rain = 1'b0;
`endif

  always_comb begin
    code_valid = 1'b1;
    level      = 2'd0;
    case ({s_high, s_mid, s_low})
      3'b000:  level = 2'd0;
      3'b001:  level = 2'd1;
      3'b011:  level = 2'd2;
      3'b111:  level = 2'd3;
      default: code_valid = 1'b0;
    endcase
  end

  assign tick       = (tick_cnt == TW'(TICK_DIV - 1));
  assign scan_step  = (scan_cnt == SW'(SCAN_DIV - 1));
  assign timer_zero = (t_tens == 4'd0) && (t_units == 4'd0);
  assign nxt_zone   = (sel == ZONE_LAST) ? '0 : sel + ZW'(1);

  // First requesting zone at or after the round-robin pointer, wrapping.
  always_comb begin
    logic [SUMW-1:0] idx;
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < ZONES; i++) begin
      idx = {1'b0, rr} + SUMW'(i);
      if (idx >= ZONES_W) idx = idx - ZONES_W;
      if (!found && zone_req[idx[ZW-1:0]]) begin
        found = 1'b1;
        pick  = idx[ZW-1:0];
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (level <= 2'd1)                 state_nx = FILL;
        else if (|zone_req && !rain)       state_nx = SELECT;
      end
      FILL:   if (level == 2'd3)           state_nx = IDLE;
      SELECT: state_nx = found ? WATER : IDLE;
      WATER: begin
        if (level == 2'd0 || timer_zero || !zone_req[sel] || rain) state_nx = IDLE;
      end
      FAULT:  if (tick && code_valid && fault_ok) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (!code_valid) state_nx = FAULT;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      rr       <= '0;
      sel      <= '0;
      t_tens   <= 4'd0;
      t_units  <= 4'd0;
      fault_ok <= 1'b0;
      buzz_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      if (state == SELECT && found) begin
        sel     <= pick;
        t_tens  <= WT_TENS;
        t_units <= WT_UNITS;
      end else if (state == WATER && tick && !timer_zero) begin
        if (t_units == 4'd0) begin
          t_units <= 4'd9;
          t_tens  <= t_tens - 4'd1;
        end else begin
          t_units <= t_units - 4'd1;
        end
      end
      if (state == WATER && state_nx != WATER) rr <= nxt_zone;
      // fault_ok remembers one valid-code tick; any invalid sample restarts the count.
      if (state == FAULT) begin
        if (!code_valid) fault_ok <= 1'b0;
        else if (tick)   fault_ok <= 1'b1;
        if (tick) buzz_q <= ~buzz_q;
      end else begin
        fault_ok <= 1'b0;
        buzz_q   <= 1'b0;
      end
    end
  end

  always_comb begin
    zone_valve = '0;
    if (state == WATER) zone_valve[sel] = 1'b1;
  end

  assign pump         = (state == FILL);
  assign led_azul     = (state == FILL);
  assign led_verde    = (state == WATER);
  assign led_vermelho = (state == FAULT);
  assign buzzer       = buzz_q && (state == FAULT);

  function automatic logic [6:0] seg_code(input logic [3:0] s);
    case (s)
      4'd0:    seg_code = 7'h01;
      4'd1:    seg_code = 7'h4F;
      4'd2:    seg_code = 7'h12;
      4'd3:    seg_code = 7'h06;
      4'd4:    seg_code = 7'h4C;
      4'd5:    seg_code = 7'h24;
      4'd6:    seg_code = 7'h20;
      4'd7:    seg_code = 7'h0F;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h04;
      SYM_F:   seg_code = 7'h38;
      SYM_DASH: seg_code = 7'h7E;
      default: seg_code = 7'h7F;
    endcase
  endfunction

  // Segments are registered for the digit that becomes active at the same edge.
  assign dig_idx_nx = scan_step ? dig_idx + 2'd1 : dig_idx;

  always_comb begin
    sym = SYM_BLANK;
    case (dig_idx_nx)
      2'd0: sym = t_units;
      2'd1: sym = t_tens;
      2'd2: sym = {2'b00, level};
      2'd3: sym = (state == WATER) ? 4'(sel) + 4'd1 : SYM_BLANK;
      default: sym = SYM_BLANK;
    endcase
    if (state == FAULT) sym = (dig_idx_nx == 2'd3) ? SYM_F : SYM_DASH;
    dot_nx = !((dig_idx_nx == 2'd2 && state == FILL) || (dig_idx_nx == 2'd3 && rain));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      dig_idx  <= 2'd0;
      seg      <= 7'h7F;
      ponto    <= 1'b1;
    end else begin
      scan_cnt <= scan_step ? '0 : scan_cnt + SW'(1);
      dig_idx  <= dig_idx_nx;
      seg      <= seg_code(sym);
      ponto    <= dot_nx;
    end
  end

  assign dig = ~(4'b0001 << dig_idx);

endmodule
